ahb_slave_data_phase: RTL and testbench

- Data-phase controller for the AHB register slave; sits directly downstream of the combinational address decoder.
- Registers the decoder's write_select, read_select and error flag at the address phase, then completes the transfer one cycle later:
  - performs the write, or
  - drives hrdata and hreadyout, or
  - issues a two-cycle ERROR response.
- Owns the slave's storage: error counter, payload low/high and data-size registers. Exports these to the core logic.

---
 rtl/ahb_slave_data_phase.sv | 151 +++++++++++++++
 tb/tb_ahb_slave_data_phase.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_data_phase.sv
`default_nettype none
// ============================================================================
// ahb_slave_data_phase: AHB register-slave data-phase controller and storage.
// Optional wait states are enabled by defining AHB_WAIT_STATE_EN.
// Revision: 1.0
// ============================================================================
module ahb_slave_data_phase #(
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    hsel_x,
  input  logic                    hready,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [1:0]              write_select,
  input  logic [1:0]              read_select,
  input  logic                    hresp_dec,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic [2*DATA_WIDTH-1:0] payload_out,
  output logic [DATA_WIDTH-1:0]   data_size_out,
  output logic                    payload_valid,
  output logic [7:0]              err_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
`ifdef AHB_WAIT_STATE_EN
    WAIT = 3'd2,
`endif
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } state_t;

  state_t                state, next_state;
  logic                  accept;
  logic                  lat_write;
  logic [1:0]            lat_wsel;
  logic [1:0]            lat_rsel;
  logic                  write_en;
  logic                  read_phase;
  logic [DATA_WIDTH-1:0] payload_lo, payload_hi, data_size;

  assign accept   = hsel_x & hready & htrans[1];
  assign write_en = (state == DATA) & lat_write;

`ifdef AHB_WAIT_STATE_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam state_t     OKAY_TARGET = WAIT;
  logic [3:0] wait_cnt;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wait_cnt <= 4'd0;
    end else if (accept && !hresp_dec) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign read_phase = ((state == DATA) || (state == WAIT)) && !lat_write;
`else
  localparam state_t OKAY_TARGET = DATA;
  assign read_phase = (state == DATA) && !lat_write;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= IDLE;
      lat_write <= 1'b0;
      lat_wsel  <= 2'd0;
      lat_rsel  <= 2'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_write <= hwrite;
        lat_wsel  <= write_select;
        lat_rsel  <= read_select;
      end
    end
  end

  always_comb begin
    next_state = IDLE;
    hreadyout  = 1'b1;
    hresp      = 1'b0;
    case (state)
      ERR1: begin
        next_state = ERR2;
        hreadyout  = 1'b0;
        hresp      = 1'b1;
      end
`ifdef AHB_WAIT_STATE_EN
      WAIT: begin
        next_state = (wait_cnt == 4'd1) ? DATA : WAIT;
        hreadyout  = 1'b0;
      end
`endif
      default: begin
        // IDLE, DATA and ERR2 can all accept a new address phase
        hresp = (state == ERR2);
        if (accept) next_state = hresp_dec ? ERR1 : OKAY_TARGET;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      payload_lo    <= '0;
      payload_hi    <= '0;
      data_size     <= '0;
      payload_valid <= 1'b0;
      err_count     <= 8'd0;
    end else begin
      payload_valid <= write_en && (lat_wsel == 2'd1);
      if (write_en) begin
        case (lat_wsel)
          2'd0:    payload_lo <= hwdata;
          2'd1:    payload_hi <= hwdata;
          2'd2:    data_size  <= hwdata;
          default: ;
        endcase
      end
      if ((next_state == ERR1) && (state != ERR1) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

  always_comb begin
    hrdata = '0;
    if (read_phase) begin
      case (lat_rsel)
        2'd0:    hrdata = {{(DATA_WIDTH-8){1'b0}}, err_count};
        2'd1:    hrdata = payload_lo;
        2'd2:    hrdata = payload_hi;
        default: hrdata = data_size;
      endcase
    end
  end

  assign payload_out   = {payload_hi, payload_lo};
  assign data_size_out = data_size;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_data_phase.sv
`default_nettype none
// Self-checking bench for ahb_slave_data_phase: random and directed transfers
// against a transaction-level model of the register slave.
module tb_ahb_slave_data_phase;

  localparam int DW = 32;
`ifdef AHB_WAIT_STATE_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif
  localparam int K_NONE = 0, K_OKAY = 1, K_ERR1 = 2, K_ERR2 = 3;

  logic            hclk = 1'b0;
  logic            hresetn;
  logic            hsel_x, hready, hwrite, hresp_dec;
  logic [1:0]      htrans, write_select, read_select;
  logic [DW-1:0]   hwdata;
  logic            hreadyout, hresp, payload_valid;
  logic [DW-1:0]   hrdata, data_size_out;
  logic [2*DW-1:0] payload_out;
  logic [7:0]      err_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model: register contents plus the one outstanding transfer
  logic [31:0] m_lo, m_hi, m_size;
  logic [7:0]  m_err;
  logic        m_pv;
  int          p_kind, p_wait;
  logic        p_write;
  logic [1:0]  p_wsel, p_rsel;
  logic [31:0] p_wdata;

  ahb_slave_data_phase #(.DATA_WIDTH(DW), .WAIT_CYCLES(2)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel_x(hsel_x), .hready(hready),
    .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata),
    .write_select(write_select), .read_select(read_select),
    .hresp_dec(hresp_dec), .hreadyout(hreadyout), .hresp(hresp),
    .hrdata(hrdata), .payload_out(payload_out), .data_size_out(data_size_out),
    .payload_valid(payload_valid), .err_count(err_count)
  );

  always #5 hclk = ~hclk;

  task automatic model_reset();
    m_lo = 0; m_hi = 0; m_size = 0; m_err = 0; m_pv = 0;
    p_kind = K_NONE; p_wait = 0; p_write = 0; p_wsel = 0; p_rsel = 0; p_wdata = 0;
  endtask

  function automatic logic [31:0] reg_value(input logic [1:0] rs);
    case (rs)
      2'd0:    return {24'd0, m_err};
      2'd1:    return m_lo;
      2'd2:    return m_hi;
      default: return m_size;
    endcase
  endfunction

  // One bus cycle, entered and left at the falling edge.
  task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic wr,
                           input logic [1:0] ws, input logic [1:0] rs,
                           input logic dec, input logic [31:0] wdata);
    logic        e_rdy, e_resp, acc;
    logic [31:0] e_rdata;
    e_rdy = 1'b1; e_resp = 1'b0; e_rdata = 32'd0;
    case (p_kind)
      K_OKAY: begin
        e_rdy = (p_wait == 0);
        if (!p_write) e_rdata = reg_value(p_rsel);
      end
      K_ERR1: begin e_rdy = 1'b0; e_resp = 1'b1; end
      K_ERR2: e_resp = 1'b1;
      default: ;
    endcase
    hsel_x = sel; htrans = trans; hwrite = wr; write_select = ws;
    read_select = rs; hresp_dec = dec; hready = e_rdy;
    hwdata = (p_kind == K_OKAY && p_write) ? p_wdata : $urandom;
    #1;
    n_checks += 7;
    if (hreadyout !== e_rdy) $display("FAIL hreadyout cyc=%0d got=%b exp=%b", cyc, hreadyout, e_rdy);
    else n_pass++;
    if (hresp !== e_resp) $display("FAIL hresp cyc=%0d got=%b exp=%b", cyc, hresp, e_resp);
    else n_pass++;
    if (hrdata !== e_rdata) $display("FAIL hrdata cyc=%0d got=%h exp=%h", cyc, hrdata, e_rdata);
    else n_pass++;
    if (payload_out !== {m_hi, m_lo}) $display("FAIL payload_out cyc=%0d got=%h exp=%h", cyc, payload_out, {m_hi, m_lo});
    else n_pass++;
    if (data_size_out !== m_size) $display("FAIL data_size_out cyc=%0d got=%h exp=%h", cyc, data_size_out, m_size);
    else n_pass++;
    if (payload_valid !== m_pv) $display("FAIL payload_valid cyc=%0d got=%b exp=%b", cyc, payload_valid, m_pv);
    else n_pass++;
    if (err_count !== m_err) $display("FAIL err_count cyc=%0d got=%h exp=%h", cyc, err_count, m_err);
    else n_pass++;

    acc  = sel & e_rdy & trans[1];
    m_pv = 1'b0;
    case (p_kind)
      K_OKAY: begin
        if (p_wait > 0) p_wait--;
        else begin
          if (p_write) begin
            if (p_wsel == 2'd0) m_lo = p_wdata;
            else if (p_wsel == 2'd1) m_hi = p_wdata;
            else if (p_wsel == 2'd2) m_size = p_wdata;
          end
          m_pv   = p_write && (p_wsel == 2'd1);
          p_kind = K_NONE;
        end
      end
      K_ERR1: p_kind = K_ERR2;
      K_ERR2: p_kind = K_NONE;
      default: ;
    endcase
    if (acc) begin
      if (dec) begin
        p_kind = K_ERR1;
        if (m_err != 8'hFF) m_err++;
      end else begin
        p_kind = K_OKAY; p_wait = WAITS; p_write = wr;
        p_wsel = ws; p_rsel = rs; p_wdata = wdata;
      end
    end
    @(posedge hclk);
    @(negedge hclk);
    cyc++;
  endtask

  task automatic idle_cycle();
    bus_cycle(1'b0, 2'b00, 1'b0, 2'd0, 2'd0, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    hresetn = 1'b0; hsel_x = 0; hready = 1; htrans = 0; hwrite = 0;
    hwdata = 0; write_select = 0; read_select = 0; hresp_dec = 0;
    model_reset();
    repeat (3) @(negedge hclk);
    n_checks += 3;
    if (hreadyout !== 1'b1 || hresp !== 1'b0)
      $display("FAIL reset_handshake got=%b%b exp=10", hreadyout, hresp);
    else n_pass++;
    if (hrdata !== 32'd0 || err_count !== 8'd0 || payload_valid !== 1'b0)
      $display("FAIL reset_outputs got=%h/%h/%b exp=0/0/0", hrdata, err_count, payload_valid);
    else n_pass++;
    if (payload_out !== 64'd0 || data_size_out !== 32'd0)
      $display("FAIL reset_regs got=%h/%h exp=0/0", payload_out, data_size_out);
    else n_pass++;
    hresetn = 1'b1;
    idle_cycle();
  endtask

  task automatic test_write_read();
    bus_cycle(1, 2'b10, 1, 2'd0, 2'd0, 0, 32'hDEADBEEF);
    bus_cycle(1, 2'b10, 0, 2'd0, 2'd1, 0, 32'd0);
    repeat (WAITS) idle_cycle();
    n_checks++;
    if (hrdata !== 32'hDEADBEEF) $display("FAIL read_lo got=%h exp=deadbeef", hrdata);
    else n_pass++;
    repeat (WAITS + 1) idle_cycle();
  endtask

  task automatic test_error();
    bus_cycle(1, 2'b10, 1, 2'd1, 2'd0, 1, 32'hFFFF0000);
    n_checks++;
    if (hreadyout !== 1'b0 || hresp !== 1'b1) $display("FAIL err1_phase got=%b%b exp=01", hreadyout, hresp);
    else n_pass++;
    repeat (3) idle_cycle();
  endtask

  task automatic test_back_to_back();
    bus_cycle(1, 2'b11, 1, 2'd1, 2'd0, 0, 32'h12345678);
    repeat (WAITS) idle_cycle();
    bus_cycle(1, 2'b11, 0, 2'd0, 2'd2, 0, 32'd0);
    n_checks++;
    if (payload_valid !== 1'b1) $display("FAIL payload_valid_pulse got=%b exp=1", payload_valid);
    else n_pass++;
    repeat (WAITS + 2) idle_cycle();
    n_checks++;
    if (payload_out[63:32] !== 32'h12345678) $display("FAIL payload_hi got=%h exp=12345678", payload_out[63:32]);
    else n_pass++;
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 520; i++) bus_cycle(1, 2'b10, 0, 2'd0, 2'd0, 1, 32'd0);
    repeat (2) idle_cycle();
    n_checks++;
    if (err_count !== 8'hFF) $display("FAIL err_saturate got=%h exp=ff", err_count);
    else n_pass++;
    bus_cycle(1, 2'b10, 0, 2'd0, 2'd0, 0, 32'd0);
    repeat (WAITS) idle_cycle();
    n_checks++;
    if (hrdata !== 32'h000000FF) $display("FAIL read_err_count got=%h exp=000000ff", hrdata);
    else n_pass++;
    repeat (WAITS + 1) idle_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r;
      r = $urandom;
      bus_cycle(r[0] | r[1], r[3:2], r[4], r[6:5], r[8:7], (r[11:9] == 3'd0), $urandom);
    end
    repeat (WAITS + 3) idle_cycle();
  endtask

  task automatic test_reset_mid_error();
    bus_cycle(1, 2'b10, 0, 2'd0, 2'd0, 1, 32'd0);
    hready = 1'b0; hsel_x = 1'b0; htrans = 2'b00;
    #1;
    n_checks++;
    if (err_count === 8'd0) $display("FAIL pre_reset_err_count got=%h exp=nonzero", err_count);
    else n_pass++;
    hresetn = 1'b0;
    #1;
    n_checks += 2;
    if (hreadyout !== 1'b1 || hresp !== 1'b0)
      $display("FAIL async_reset_handshake got=%b%b exp=10", hreadyout, hresp);
    else n_pass++;
    if (err_count !== 8'd0 || payload_out !== 64'd0)
      $display("FAIL async_reset_regs got=%h/%h exp=0/0", err_count, payload_out);
    else n_pass++;
    model_reset();
    @(negedge hclk);
    hresetn = 1'b1;
    repeat (3) idle_cycle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_error();
    test_back_to_back();
    test_err_saturate();
    test_reset_mid_error();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
